// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the in-order
// pipeline (port 0) and the multicycle unit (port 1) using round-robin
// valid/ready arbitration. The winning write is driven from a registered stage.
// A busy scoreboard tracks outstanding multicycle writes so decode can detect
// read hazards.
// Optional feature macro: RF_BYPASS_EN adds a write-then-read bypass on both
// read ports, and suppresses the hazard on a read select that the bypass serves.
module regfile_wb_arbiter #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned SEL_W  = $clog2(NREGS)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              wb0_valid,
  output logic              wb0_ready,
  input  logic [SEL_W-1:0]  wb0_sel,
  input  logic [WORD_W-1:0] wb0_dat,
  input  logic              wb1_valid,
  output logic              wb1_ready,
  input  logic [SEL_W-1:0]  wb1_sel,
  input  logic [WORD_W-1:0] wb1_dat,
  input  logic              iss_valid,
  input  logic [SEL_W-1:0]  iss_sel,
  input  logic [SEL_W-1:0]  rsel1,
  input  logic [SEL_W-1:0]  rsel2,
  output logic              hazard,
  output logic              WEN,
  output logic [SEL_W-1:0]  wsel,
  output logic [WORD_W-1:0] wdat
`ifdef RF_BYPASS_EN
  ,
  input  logic [WORD_W-1:0] rf_rdat1,
  input  logic [WORD_W-1:0] rf_rdat2,
  output logic [WORD_W-1:0] byp_rdat1,
  output logic [WORD_W-1:0] byp_rdat2
`endif
);

  logic              rr_ptr;
  logic              contended;
  logic              acc0;
  logic              acc1;
  logic              wr_go;
  logic [SEL_W-1:0]  win_sel;
  logic [WORD_W-1:0] win_dat;
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_nxt;

  // Grant: a lone requester wins; on contention the port named by rr_ptr wins.
  always_comb begin
    wb0_ready = 1'b0;
    wb1_ready = 1'b0;
    contended = wb0_valid & wb1_valid;
    if (nRST) begin
      if (contended) begin
        wb0_ready = ~rr_ptr;
        wb1_ready = rr_ptr;
      end else begin
        wb0_ready = wb0_valid;
        wb1_ready = wb1_valid;
      end
    end
  end

  // Select the accepted request; register 0 is accepted but never written.
  always_comb begin
    acc0    = wb0_valid & wb0_ready;
    acc1    = wb1_valid & wb1_ready;
    win_sel = acc1 ? wb1_sel : wb0_sel;
    win_dat = acc1 ? wb1_dat : wb0_dat;
    wr_go   = (acc0 | acc1) & (win_sel != '0);
  end

  // Scoreboard next state: clear on wb1 accept, then set on issue so set wins.
  always_comb begin
    busy_nxt = busy;
    if (acc1) begin
      busy_nxt[wb1_sel] = 1'b0;
    end
    if (iss_valid && (iss_sel != '0)) begin
      busy_nxt[iss_sel] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Round-robin pointer moves to the loser only when both ports competed.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr <= 1'b0;
    end else if (contended) begin
      rr_ptr <= ~rr_ptr;
    end
  end

  // Busy scoreboard register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Registered write stage: one cycle from accept to WEN; select/data hold when idle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      WEN  <= 1'b0;
      wsel <= '0;
      wdat <= '0;
    end else if (wr_go) begin
      WEN  <= 1'b1;
      wsel <= win_sel;
      wdat <= win_dat;
    end else begin
      WEN  <= 1'b0;
    end
  end

`ifdef RF_BYPASS_EN
  logic byp_hit1;
  logic byp_hit2;

  // Forward the write in flight to a reader of the same register, and mask its hazard.
  always_comb begin
    byp_hit1  = WEN && (wsel == rsel1) && (rsel1 != '0);
    byp_hit2  = WEN && (wsel == rsel2) && (rsel2 != '0);
    byp_rdat1 = byp_hit1 ? wdat : rf_rdat1;
    byp_rdat2 = byp_hit2 ? wdat : rf_rdat2;
    hazard    = (busy[rsel1] & ~byp_hit1) | (busy[rsel2] & ~byp_hit2);
  end
`else
  // Hazard from the current scoreboard contents.
  always_comb begin
    hazard = busy[rsel1] | busy[rsel2];
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a table of per-cycle vectors plus
// hand-written sequences for reset behaviour and the optional bypass.
module tb_regfile_wb_arbiter;

  logic        CLK;
  logic        nRST;
  logic        wb0_valid, wb1_valid, iss_valid;
  logic        wb0_ready, wb1_ready, hazard, WEN;
  logic [4:0]  wb0_sel, wb1_sel, iss_sel, rsel1, rsel2, wsel;
  logic [31:0] wb0_dat, wb1_dat, wdat;
`ifdef RF_BYPASS_EN
  logic [31:0] rf_rdat1, rf_rdat2, byp_rdat1, byp_rdat2;
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_sel(wb0_sel), .wb0_dat(wb0_dat),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_sel(wb1_sel), .wb1_dat(wb1_dat),
    .iss_valid(iss_valid), .iss_sel(iss_sel),
    .rsel1(rsel1), .rsel2(rsel2), .hazard(hazard),
    .WEN(WEN), .wsel(wsel), .wdat(wdat)
`ifdef RF_BYPASS_EN
    , .rf_rdat1(rf_rdat1), .rf_rdat2(rf_rdat2), .byp_rdat1(byp_rdat1), .byp_rdat2(byp_rdat2)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic v0; logic [4:0] s0; logic [31:0] d0;
    logic v1; logic [4:0] s1; logic [31:0] d1;
    logic iv; logic [4:0] isel;
    logic [4:0] r1; logic [4:0] r2;
    logic e_r0; logic e_r1; logic e_haz; logic e_wen;
    logic chk_wd; logic [4:0] e_wsel; logic [31:0] e_wdat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v0, logic [4:0] s0, logic [31:0] d0,
                              logic v1, logic [4:0] s1, logic [31:0] d1,
                              logic iv, logic [4:0] isel, logic [4:0] r1, logic [4:0] r2,
                              logic er0, logic er1, logic ehaz, logic ewen,
                              logic cwd, logic [4:0] ews, logic [31:0] ewd);
    vec_t v;
    v.v0 = v0; v.s0 = s0; v.d0 = d0; v.v1 = v1; v.s1 = s1; v.d1 = d1;
    v.iv = iv; v.isel = isel; v.r1 = r1; v.r2 = r2;
    v.e_r0 = er0; v.e_r1 = er1; v.e_haz = ehaz; v.e_wen = ewen;
    v.chk_wd = cwd; v.e_wsel = ews; v.e_wdat = ewd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wb0_valid = 1'b0; wb0_sel = '0; wb0_dat = '0;
    wb1_valid = 1'b0; wb1_sel = '0; wb1_dat = '0;
    iss_valid = 1'b0; iss_sel = '0; rsel1 = '0; rsel2 = '0;
  endtask

  initial begin
    idle_inputs();
`ifdef RF_BYPASS_EN
    rf_rdat1 = 32'hA1A1_A1A1;
    rf_rdat2 = 32'hB2B2_B2B2;
`endif
    // vector table: v0..v24, registered expectations are after the edge
    vecs.push_back(mk(1,5,32'hDEADBEEF, 0,0,0,  0,0, 0,0,  1,0,0,1, 1,5,32'hDEADBEEF));
    vecs.push_back(mk(0,0,0,            0,0,0,  0,0, 0,0,  0,0,0,0, 1,5,32'hDEADBEEF));
    vecs.push_back(mk(1,3,32'h33,       1,7,32'h77, 0,0, 0,0, 1,0,0,1, 1,3,32'h33));
    vecs.push_back(mk(1,3,32'h33,       1,7,32'h77, 0,0, 0,0, 0,1,0,1, 1,7,32'h77));
    vecs.push_back(mk(1,3,32'h33,       1,7,32'h77, 0,0, 0,0, 1,0,0,1, 1,3,32'h33));
    vecs.push_back(mk(1,3,32'h33,       1,7,32'h77, 0,0, 0,0, 0,1,0,1, 1,7,32'h77));
    vecs.push_back(mk(0,0,0,            1,4,32'h44, 0,0, 0,0, 0,1,0,1, 1,4,32'h44));
    vecs.push_back(mk(1,3,32'h3A,       1,7,32'h7A, 0,0, 0,0, 1,0,0,1, 1,3,32'h3A));
    vecs.push_back(mk(1,2,32'h22,       0,0,0,      0,0, 0,0, 1,0,0,1, 1,2,32'h22));
    vecs.push_back(mk(1,3,32'h3B,       1,7,32'h7B, 0,0, 0,0, 0,1,0,1, 1,7,32'h7B));
    vecs.push_back(mk(0,0,0, 0,0,0,          1,9, 9,0, 0,0,0,0, 1,7,32'h7B));
    vecs.push_back(mk(0,0,0, 0,0,0,          0,0, 9,0, 0,0,1,0, 1,7,32'h7B));
    vecs.push_back(mk(0,0,0, 1,9,32'h99,     0,0, 9,0, 0,1,1,1, 1,9,32'h99));
    vecs.push_back(mk(0,0,0, 0,0,0,          0,0, 9,0, 0,0,0,0, 1,9,32'h99));
    vecs.push_back(mk(0,0,0, 0,0,0,          1,9, 0,9, 0,0,0,0, 1,9,32'h99));
    vecs.push_back(mk(0,0,0, 1,9,32'h98,     1,9, 0,9, 0,1,1,1, 1,9,32'h98));
    vecs.push_back(mk(0,0,0, 0,0,0,          0,0, 0,9, 0,0,!BYP,0, 1,9,32'h98));
    vecs.push_back(mk(0,0,0, 0,0,0,          1,9, 9,3, 0,0,1,0, 1,9,32'h98));
    vecs.push_back(mk(0,0,0, 1,9,32'h97,     0,0, 0,9, 0,1,1,1, 1,9,32'h97));
    vecs.push_back(mk(0,0,0, 0,0,0,          0,0, 9,0, 0,0,0,0, 1,9,32'h97));
    vecs.push_back(mk(0,0,0, 0,0,0,          1,0, 0,0, 0,0,0,0, 1,9,32'h97));
    vecs.push_back(mk(0,0,0, 0,0,0,          0,0, 0,0, 0,0,0,0, 1,9,32'h97));
    vecs.push_back(mk(1,0,32'hFFFFFFFF, 0,0,0, 0,0, 0,0, 1,0,0,0, 0,0,0));
    vecs.push_back(mk(1,1,32'h11,       0,0,0, 0,0, 0,0, 1,0,0,1, 1,1,32'h11));
    vecs.push_back(mk(0,0,0,            1,0,32'h5A, 0,0, 0,0, 0,1,0,0, 0,0,0));

    // reset with a pending request: nothing granted, nothing written
    nRST = 1'b0;
    wb0_valid = 1'b1; wb0_sel = 5'd5; wb0_dat = 32'hDEADBEEF;
    #12;
    chk("rst_wb0_ready", 32'(wb0_ready), 32'd0);
    chk("rst_WEN", 32'(WEN), 32'd0);
    chk("rst_wsel", 32'(wsel), 32'd0);
    chk("rst_wdat", wdat, 32'd0);
    chk("rst_hazard", 32'(hazard), 32'd0);
    @(posedge CLK); #1;
    chk("rst_edge_WEN", 32'(WEN), 32'd0);
    #2 nRST = 1'b1;
    #1;
    chk("rel_wb0_ready", 32'(wb0_ready), 32'd1);

    foreach (vecs[i]) begin
      wb0_valid = vecs[i].v0; wb0_sel = vecs[i].s0; wb0_dat = vecs[i].d0;
      wb1_valid = vecs[i].v1; wb1_sel = vecs[i].s1; wb1_dat = vecs[i].d1;
      iss_valid = vecs[i].iv; iss_sel = vecs[i].isel;
      rsel1 = vecs[i].r1; rsel2 = vecs[i].r2;
      #3;
      chk($sformatf("v%0d_wb0_ready", i), 32'(wb0_ready), 32'(vecs[i].e_r0));
      chk($sformatf("v%0d_wb1_ready", i), 32'(wb1_ready), 32'(vecs[i].e_r1));
      chk($sformatf("v%0d_hazard", i), 32'(hazard), 32'(vecs[i].e_haz));
      @(posedge CLK); #1;
      chk($sformatf("v%0d_WEN", i), 32'(WEN), 32'(vecs[i].e_wen));
      if (vecs[i].chk_wd) begin
        chk($sformatf("v%0d_wsel", i), 32'(wsel), 32'(vecs[i].e_wsel));
        chk($sformatf("v%0d_wdat", i), wdat, vecs[i].e_wdat);
      end
    end

    // async reset mid-transfer drops the request and clears the scoreboard
    idle_inputs();
    iss_valid = 1'b1; iss_sel = 5'd12;
    @(posedge CLK); #1;
    iss_valid = 1'b0; iss_sel = '0;
    wb0_valid = 1'b1; wb0_sel = 5'd6; wb0_dat = 32'h66;
    rsel1 = 5'd12;
    #1;
    chk("mid_hazard_before", 32'(hazard), 32'd1);
    chk("mid_ready_before", 32'(wb0_ready), 32'd1);
    nRST = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(wb0_ready), 32'd0);
    chk("mid_rst_hazard", 32'(hazard), 32'd0);
    chk("mid_rst_wsel", 32'(wsel), 32'd0);
    chk("mid_rst_wdat", wdat, 32'd0);
    @(posedge CLK); #1;
    chk("mid_rst_WEN", 32'(WEN), 32'd0);
    #2 nRST = 1'b1;
    #1;
    chk("mid_rel_ready", 32'(wb0_ready), 32'd1);
    chk("mid_rel_hazard", 32'(hazard), 32'd0);
    @(posedge CLK); #1;
    wb0_valid = 1'b0;
    chk("mid_re_WEN", 32'(WEN), 32'd1);
    chk("mid_re_wsel", 32'(wsel), 32'd6);
    chk("mid_re_wdat", wdat, 32'h66);

`ifdef RF_BYPASS_EN
    // bypass while WEN=1 wsel=6 wdat=0x66
    rsel1 = 5'd6; rsel2 = 5'd0;
    #1;
    chk("byp1_hit", byp_rdat1, 32'h66);
    chk("byp2_zero_sel", byp_rdat2, 32'hB2B2_B2B2);
    rsel1 = 5'd0; rsel2 = 5'd6;
    #1;
    chk("byp1_zero_sel", byp_rdat1, 32'hA1A1_A1A1);
    chk("byp2_hit", byp_rdat2, 32'h66);
    @(posedge CLK); #1;
    chk("byp2_after_WEN0", byp_rdat2, 32'hB2B2_B2B2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
